// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the request encoders.
// Index sizing and pointer wrap are kept here so every unit agrees.
package encoder_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Index width, never below one bit.
  function automatic int idx_width(input int n);
    return $clog2((n > 2) ? n : 2);
  endfunction

  // Increment with an explicit wrap at n.
  // Values past n-1 never reach the pointer.
  function automatic int wrap_inc(input int v, input int n);
    return ((v + 1) == n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/lsb_priority_encoder.sv
// Lowest-set-bit encoder.
// Purely combinational; index is 0 when nothing is set.
module lsb_priority_encoder
  import encoder_pkg::*;
#(
  parameter  int INPUT_WIDTH = 4,
  localparam int IDX_WIDTH   = idx_width(INPUT_WIDTH)
) (
  input  logic [INPUT_WIDTH-1:0] req_i,
  output logic                   found_o,
  output logic [IDX_WIDTH-1:0]   index_o
);

  // Scan from the top so the lowest set bit is written last.
  always_comb begin
    found_o = |req_i;
    index_o = '0;
    for (int i = INPUT_WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) index_o = IDX_WIDTH'(i);
    end
  end

endmodule

// File: rtl/rr_encoder.sv
// Registered request encoder with valid/ready output.
// Fixed or rotating priority, selected by ROUND_ROBIN.
module rr_encoder
  import encoder_pkg::*;
#(
  parameter  int INPUT_WIDTH = 4,
  parameter  int ROUND_ROBIN = ARB_RR,
  localparam int IDX_WIDTH   = idx_width(INPUT_WIDTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [INPUT_WIDTH-1:0] req_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [IDX_WIDTH-1:0]   index_o,
  output logic [INPUT_WIDTH-1:0] grant_o,
  output logic [IDX_WIDTH-1:0]   ptr_o
);

  logic                   valid_q, valid_d;
  logic [IDX_WIDTH-1:0]   index_q, index_d;
  logic [INPUT_WIDTH-1:0] grant_q, grant_d;
  logic [IDX_WIDTH-1:0]   ptr_q, ptr_d;

  logic                   acc, load;
  logic [INPUT_WIDTH-1:0] req_masked;
  logic                   m_found, u_found;
  logic [IDX_WIDTH-1:0]   m_idx, u_idx, sel;

  // Handshake and next pointer; a same-cycle load sees the advanced pointer.
  always_comb begin
    acc   = valid_q & ready_i;
    load  = ~valid_q | acc;
    ptr_d = ptr_q;
    if (ROUND_ROBIN == ARB_RR && acc)
      ptr_d = IDX_WIDTH'(wrap_inc(int'(index_q), INPUT_WIDTH));
  end

  // Keep only requesters at or above the priority pointer.
  always_comb begin
    req_masked = '0;
    for (int k = 0; k < INPUT_WIDTH; k++) begin
      req_masked[k] = req_i[k] & (k >= int'(ptr_d));
    end
  end

  lsb_priority_encoder #(
    .INPUT_WIDTH(INPUT_WIDTH)
  ) u_masked (
    .req_i  (req_masked),
    .found_o(m_found),
    .index_o(m_idx)
  );

  lsb_priority_encoder #(
    .INPUT_WIDTH(INPUT_WIDTH)
  ) u_unmasked (
    .req_i  (req_i),
    .found_o(u_found),
    .index_o(u_idx)
  );

  // Output register next state: load a fresh selection or hold.
  always_comb begin
    sel     = m_found ? m_idx : u_idx;
    valid_d = valid_q;
    index_d = index_q;
    grant_d = grant_q;
    if (load) begin
      if (u_found) begin
        valid_d = 1'b1;
        index_d = sel;
        grant_d = INPUT_WIDTH'(1) << sel;
      end else begin
        valid_d = 1'b0;
        grant_d = '0;
      end
    end
  end

  // State registers; reset wins over any handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      index_q <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      index_q <= index_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign valid_o = valid_q;
  assign index_o = index_q;
  assign grant_o = grant_q;
  assign ptr_o   = ptr_q;

endmodule

// File: tb/tb_rr_encoder.sv
// Directed bench for rr_encoder.
// Four instances cover W=5/4 rotating, W=8 fixed and W=1.
module tb_rr_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // W=5 rotating
  logic       rst5, rdy5, v5;
  logic [4:0] req5, g5;
  logic [2:0] i5, p5;
  rr_encoder #(.INPUT_WIDTH(5), .ROUND_ROBIN(1)) u5 (
    .clk_i(clk), .rst_i(rst5), .req_i(req5), .valid_o(v5),
    .ready_i(rdy5), .index_o(i5), .grant_o(g5), .ptr_o(p5)
  );

  // W=4 rotating
  logic       rst4, rdy4, v4;
  logic [3:0] req4, g4;
  logic [1:0] i4, p4;
  rr_encoder #(.INPUT_WIDTH(4), .ROUND_ROBIN(1)) u4 (
    .clk_i(clk), .rst_i(rst4), .req_i(req4), .valid_o(v4),
    .ready_i(rdy4), .index_o(i4), .grant_o(g4), .ptr_o(p4)
  );

  // W=8 fixed
  logic       rst8, rdy8, v8;
  logic [7:0] req8, g8;
  logic [2:0] i8, p8;
  rr_encoder #(.INPUT_WIDTH(8), .ROUND_ROBIN(0)) u8 (
    .clk_i(clk), .rst_i(rst8), .req_i(req8), .valid_o(v8),
    .ready_i(rdy8), .index_o(i8), .grant_o(g8), .ptr_o(p8)
  );

  // W=1
  logic       rst1, rdy1, v1;
  logic [0:0] req1, g1, i1, p1;
  rr_encoder #(.INPUT_WIDTH(1), .ROUND_ROBIN(1)) u1 (
    .clk_i(clk), .rst_i(rst1), .req_i(req1), .valid_o(v1),
    .ready_i(rdy1), .index_o(i1), .grant_o(g1), .ptr_o(p1)
  );

  int exp_i[6];
  int exp_p[6];

  initial begin
    rst5 = 1; rst4 = 1; rst8 = 1; rst1 = 1;
    rdy5 = 0; rdy4 = 0; rdy8 = 0; rdy1 = 0;
    req5 = '0; req4 = '0; req8 = '0; req1 = '0;

    // 1: W=5 RR, req 10110
    req5 = 5'b10110; rdy5 = 1;
    step();
    chk("t1 rst valid", 32'(v5), 0);
    chk("t1 rst index", 32'(i5), 0);
    chk("t1 rst grant", 32'(g5), 0);
    chk("t1 rst ptr", 32'(p5), 0);
    rst5 = 0;
    exp_i = '{1, 2, 4, 1, 2, 4};
    exp_p = '{0, 2, 3, 0, 2, 3};
    for (int n = 0; n < 6; n++) begin
      step();
      chk($sformatf("t1 valid %0d", n), 32'(v5), 1);
      chk($sformatf("t1 index %0d", n), 32'(i5), 32'(exp_i[n]));
      chk($sformatf("t1 grant %0d", n), 32'(g5), 32'(1 << exp_i[n]));
      chk($sformatf("t1 ptr %0d", n), 32'(p5), 32'(exp_p[n]));
    end

    // 2: W=5 RR, req 10001, wrap check
    rst5 = 1; req5 = 5'b10001;
    step();
    rst5 = 0;
    exp_i = '{0, 4, 0, 4, 0, 4};
    exp_p = '{0, 1, 0, 1, 0, 1};
    for (int n = 0; n < 6; n++) begin
      step();
      chk($sformatf("t2 index %0d", n), 32'(i5), 32'(exp_i[n]));
      chk($sformatf("t2 ptr %0d", n), 32'(p5), 32'(exp_p[n]));
    end
    rst5 = 1;

    // 3: W=4 backpressure
    req4 = 4'b1000; rdy4 = 0;
    step();
    rst4 = 0;
    step();
    chk("t3 first valid", 32'(v4), 1);
    chk("t3 first index", 32'(i4), 3);
    req4 = 4'b0001;
    for (int n = 0; n < 3; n++) begin
      step();
      chk($sformatf("t3 hold valid %0d", n), 32'(v4), 1);
      chk($sformatf("t3 hold index %0d", n), 32'(i4), 3);
      chk($sformatf("t3 hold grant %0d", n), 32'(g4), 32'h8);
    end
    rdy4 = 1;
    step();
    chk("t3 release index", 32'(i4), 0);
    chk("t3 release ptr", 32'(p4), 0);

    // 5: reserve mid-operation on W=4
    req4 = 4'b1010;
    step();
    chk("t5 setup index a", 32'(i4), 1);
    step();
    chk("t5 setup index b", 32'(i4), 3);
    chk("t5 setup ptr", 32'(p4), 2);
    chk("t5 setup valid", 32'(v4), 1);
    rst4 = 1;
    step();
    chk("t5 rst valid", 32'(v4), 0);
    chk("t5 rst grant", 32'(g4), 0);
    chk("t5 rst ptr", 32'(p4), 0);
    rst4 = 0;
    step();
    chk("t5 post index", 32'(i4), 1);
    chk("t5 post grant", 32'(g4), 32'h2);

    // 4: W=8 fixed priority
    req8 = 8'b1010_0100; rdy8 = 1;
    step();
    rst8 = 0;
    for (int n = 0; n < 4; n++) begin
      step();
      chk($sformatf("t4 valid %0d", n), 32'(v8), 1);
      chk($sformatf("t4 index %0d", n), 32'(i8), 2);
      chk($sformatf("t4 ptr %0d", n), 32'(p8), 0);
    end

    // 6: W=1
    req1 = 1'b1; rdy1 = 0;
    step();
    chk("t6 rst valid", 32'(v1), 0);
    rst1 = 0;
    for (int n = 0; n < 4; n++) begin
      step();
      chk($sformatf("t6 valid %0d", n), 32'(v1), 1);
      chk($sformatf("t6 index %0d", n), 32'(i1), 0);
      chk($sformatf("t6 grant %0d", n), 32'(g1), 32'(v1));
      chk($sformatf("t6 ptr %0d", n), 32'(p1), 0);
      rdy1 = ~rdy1;
    end
    req1 = 1'b0; rdy1 = 1;
    step();
    chk("t6 drop valid", 32'(v1), 0);
    chk("t6 drop grant", 32'(g1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
